// File: rtl/add_sequencer.sv
// add_sequencer: N-bit adder (N = SLICE*WORDS) built from one shared SLICE-bit
// ripple-carry adder, processing one slice per cycle from LSB to MSB.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a new operand set; no result held
//   RUN   | adding slice idx into s, carry propagated through carry_q
//   DONE  | s / c_out complete and held until the consumer takes them

// Team ripple-carry adder: n-bit sum of a, b and c_in with carry out.
module rcanbit #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] s,
  output logic         c_out
);

  logic c;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    s = '0;
    c = c_in;
    for (int i = 0; i < n; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

module add_sequencer #(
  parameter int SLICE = 16,
  parameter int WORDS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE*WORDS-1:0]   a,
  input  logic [SLICE*WORDS-1:0]   b,
  input  logic                     c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE*WORDS-1:0]   s,
  output logic                     c_out
);

  localparam int N     = SLICE * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_s;
  logic             slice_co;

  // Select the current slice of the captured operands.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = a_q[i*SLICE +: SLICE];
        slice_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  rcanbit #(.n(SLICE)) u_slice_adder (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_co)
  );

  // Sequencer FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      s         <= '0;
      c_out     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= c_in;
            idx      <= '0;
            s        <= '0;
            c_out    <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
              s[i*SLICE +: SLICE] <= slice_s;
            end
          end
          carry_q <= slice_co;
          if (idx == LAST_IDX) begin
            c_out     <= slice_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Directed and randomized checks for add_sequencer at default parameters.
module tb_add_sequencer;

  localparam int SLICE = 16;
  localparam int WORDS = 3;
  localparam int N     = SLICE * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         c_out;

  int n_checks;
  int n_fail;
  int cyc;

  add_sequencer #(.SLICE(SLICE), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
    n_checks++;
    if ({c_out, s} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_result: c_out=%b s=%h required 0/0", c_out, s);
    end
    // out_ready in IDLE has no effect
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_out_ready: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_carry_ripple();
    int n;
    a = 48'hFFFF_FFFF_FFFF; b = 48'h0000_0000_0001; c_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ripple_run_ready: in_ready=%b required 0", in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL ripple_latency: %0d cycles required 3", n);
    end
    n_checks++;
    if (s !== 48'h0000_0000_0000 || c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple_result: c_out=%b s=%h required 1/000000000000", c_out, s);
    end
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL ripple_return: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_mid_slice();
    int n;
    a = 48'h0000_FFFF_0000; b = 48'h0000_0001_0000; c_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3 || s !== 48'h0001_0000_0001 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_slice: cycles=%0d c_out=%b s=%h required 3 0/000100000001", n, c_out, s);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    a = 48'h8000_0000_0000; b = 48'h8000_0000_0000; c_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = 48'h0000_0000_FFFF; b = 48'h0000_0000_0001; c_in = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL bp_latency: %0d cycles required 3", n);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 48'h0000_0000_0001 || c_out !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b c_out=%b s=%h required 1 0 1/000000000001",
                 i, out_valid, in_ready, c_out, s);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b1 || s !== 48'h0000_0000_0001 || c_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold_end: out_valid=%b c_out=%b s=%h required 1 1/000000000001", out_valid, c_out, s);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release: in_ready/out_valid=%b required 10", {in_ready, out_valid});
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready);
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 3 || s !== 48'h0000_0001_0000 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: cycles=%0d c_out=%b s=%h required 3 0/000000010000", n, c_out, s);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    a = 48'hFFFF_FFFF_FFFF; b = 48'h0000_0000_0001; c_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10 || s !== 48'd0 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b c_out=%b s=%h required 1 0 0/0",
               in_ready, out_valid, c_out, s);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_result: out_valid seen %0d times required 0", seen);
    end
  endtask

  task automatic test_isolation();
    int n;
    a = 48'h1111_2222_3333; b = 48'h4444_5555_6666; c_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      a = 48'({$urandom(), $urandom()});
      b = 48'({$urandom(), $urandom()});
      c_in = 1'($urandom());
      tick(); n++;
    end
    n_checks++;
    if (n != 3 || s !== 48'h5555_7777_9999 || c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL isolation: cycles=%0d c_out=%b s=%h required 3 0/555577779999", n, c_out, s);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N:0] expect_sum;
    int last_acc;
    int n;
    int bad_sum;
    int bad_gap;
    bad_sum = 0; bad_gap = 0; last_acc = 0;
    a = 48'({$urandom(), $urandom()});
    b = 48'({$urandom(), $urandom()});
    c_in = 1'($urandom());
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      expect_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};
      tick();
      if (i > 0) begin
        n_checks++;
        if (cyc - last_acc != 5) begin
          n_fail++;
          if (bad_gap < 5) $display("FAIL b2b_gap[%0d]: %0d cycles required 5", i, cyc - last_acc);
          bad_gap++;
        end
      end
      last_acc = cyc;
      a = 48'({$urandom(), $urandom()});
      b = 48'({$urandom(), $urandom()});
      c_in = 1'($urandom());
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
      n_checks++;
      if ({c_out, s} !== expect_sum) begin
        n_fail++;
        if (bad_sum < 5) $display("FAIL b2b_sum[%0d]: got %h required %h", i, {c_out, s}, expect_sum);
        bad_sum++;
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_carry_ripple();
    test_mid_slice();
    test_backpressure();
    test_reset_mid();
    test_isolation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 The block SHALL have parameter SLICE, default 16, giving the width of the single shared adder slice in bits.
REQ-002 The block SHALL have parameter WORDS, default 3, giving the number of slices per operand; N = SLICE*WORDS (48 at defaults).
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: in_valid  input  1  operand set a, b, c_in presented.
REQ-006 Port: in_ready  output  1  block accepts an operand set this cycle.
REQ-007 Port: a  input  N  operand A.
REQ-008 Port: b  input  N  operand B.
REQ-009 Port: c_in  input  1  carry into the least-significant slice.
REQ-010 Port: out_valid  output  1  s and c_out hold a completed result.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: s  output  N  registered sum.
REQ-013 Port: c_out  output  1  registered carry out of the most-significant slice.

Function
REQ-014 The block SHALL compute {c_out, s} = a + b + c_in modulo 2^(N+1), using exactly one instance of the team ripple-carry adder rcanbit with n=SLICE, time-shared across slices.
REQ-015 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE: in_ready=1, out_valid=0.
REQ-017 In IDLE, when in_valid=1: capture a, b and c_in into internal registers, clear slice index to 0 and s to 0, and go to RUN.
REQ-018 In RUN, each cycle: add slice idx of captured a and b (bits idx*SLICE+SLICE-1 .. idx*SLICE) with the carry register; write the result into the same bits of s; load the adder carry-out into the carry register; increment idx.
REQ-019 The carry register SHALL be loaded with c_in at capture.
REQ-020 When the slice with idx=WORDS-1 is processed: load c_out from that slice's carry-out and go to DONE.
REQ-021 Latency: input accepted on edge k implies out_valid=1 after edge k+WORDS (3 at defaults).
REQ-022 In DONE: out_valid=1, in_ready=0, and s and c_out are held stable.
REQ-023 When out_ready=1 in DONE, the block SHALL return to IDLE on that edge.
REQ-024 While out_ready=0 in DONE, the block SHALL stay in DONE indefinitely.
REQ-025 in_ready SHALL be 0 in RUN and DONE; in_valid SHALL be ignored in those states, with no overlap of operations and no queuing.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 Maximum throughput SHALL be one result per WORDS+2 cycles.
REQ-028 WORDS=1 SHALL be supported: RUN lasts one cycle.
REQ-029 a and b SHALL be sampled only at acceptance; later input changes do not affect the result in progress.

Reset
REQ-030 rst=1 on a clock edge SHALL force state IDLE, idx=0, carry register=0, s=0, c_out=0 and captured operands=0, so that out_valid=0 and in_ready=1 in the following cycle.
REQ-031 Reset during RUN or DONE SHALL abort the operation and discard the result; no out_valid pulse follows.
REQ-032 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-033 Carry ripple: a=0xFFFF_FFFF_FFFF, b=0x0000_0000_0001, c_in=0, out_ready=1 -> out_valid 3 cycles after accept; s=0x0000_0000_0000, c_out=1.
REQ-034 Mid-slice carry: a=0x0000_FFFF_0000, b=0x0000_0001_0000, c_in=1 -> s=0x0001_0000_0001, c_out=0.
REQ-035 Backpressure: complete an add with out_ready=0 for 5 cycles while in_valid=1 with new operands -> s and c_out are unchanged, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, and the new operands are accepted in the following cycle.
REQ-036 Reset mid-operation: rst=1 on the second RUN cycle -> next cycle out_valid=0, in_ready=1, s=0, c_out=0; no result is later produced.
REQ-037 Back-to-back: in_valid=1 and out_ready=1 held with random operands over 1000 operations -> each result matches the reference a+b+c_in, and accepts occur exactly every 5 cycles.
REQ-038 Input isolation: change a and b every cycle during RUN -> the result equals the sum of the values captured at accept.
